// File: rtl/idct_pkg.sv
// Shared FP32 constants and arithmetic helpers for the inverse-DCT stages.
// The add/sub/mul helpers model the team FP cores' arithmetic; latency is added by delay lines.
package idct_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned ROW_W = 3;

  localparam logic [FP_W-1:0] INV_SQRT2 = 32'h3F3504F3;
  localparam logic [FP_W-1:0] QNAN      = 32'h7FC00000;
  localparam logic [7:0]      EXP_ZERO  = 8'h00;
  localparam logic [7:0]      EXP_MIN   = 8'h01;
  localparam logic [7:0]      EXP_MAX   = 8'hFF;

  // Divide by two via the exponent field; the smallest normal flushes to signed zero.
  function automatic logic [FP_W-1:0] fp_half(input logic [FP_W-1:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (e == EXP_ZERO || e == EXP_MAX) return x;
    if (e == EXP_MIN) return {x[31], 31'd0};
    return {x[31], e - 8'd1, x[22:0]};
  endfunction

  // m holds 24 significand bits above guard, round and sticky; e >= 1.
  function automatic logic [FP_W-1:0] fp_round_pack(input logic s, input int e,
                                                    input logic [26:0] m);
    logic [24:0] r;
    logic        inc;
    int          ex;
    ex  = e;
    inc = m[2] && (m[1] || m[0] || m[3]);
    r   = {1'b0, m[26:3]} + {24'd0, inc};
    if (r[24]) begin
      r  = r >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {s, EXP_MAX, 23'd0};
    return {s, r[23] ? 8'(ex) : EXP_ZERO, r[22:0]};
  endfunction

  function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] a,
                                             input logic [FP_W-1:0] b);
    logic [FP_W-1:0] x, y;
    logic [26:0]     am, bm, al, mask;
    logic [27:0]     s;
    int              exa, exb, sh, ex;
    if ((a[30:23] == EXP_MAX && a[22:0] != 23'd0) ||
        (b[30:23] == EXP_MAX && b[22:0] != 23'd0)) return QNAN;
    if (a[30:23] == EXP_MAX) begin
      if (b[30:23] == EXP_MAX && a[31] != b[31]) return QNAN;
      return a;
    end
    if (b[30:23] == EXP_MAX) return b;
    // x is the operand of larger magnitude and sets the result sign
    if (b[30:0] > a[30:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    exa = (x[30:23] == EXP_ZERO) ? 1 : int'(x[30:23]);
    exb = (y[30:23] == EXP_ZERO) ? 1 : int'(y[30:23]);
    am  = {x[30:23] != EXP_ZERO, x[22:0], 3'b000};
    bm  = {y[30:23] != EXP_ZERO, y[22:0], 3'b000};
    sh  = exa - exb;
    if (sh >= 27) begin
      al = {26'd0, |bm};
    end else begin
      mask = (27'd1 << sh) - 27'd1;
      al   = (bm >> sh) | {26'd0, |(bm & mask)};
    end
    ex = exa;
    if (x[31] == y[31]) begin
      s = {1'b0, am} + {1'b0, al};
      if (s[27]) begin
        s  = (s >> 1) | {27'd0, s[0]};
        ex = ex + 1;
      end
    end else begin
      s = {1'b0, am} - {1'b0, al};
      if (s == 28'd0) return 32'd0;
      for (int i = 0; i < 27; i++) begin
        if (!s[26] && ex > 1) begin
          s  = s << 1;
          ex = ex - 1;
        end
      end
    end
    return fp_round_pack(x[31], ex, s[26:0]);
  endfunction

  function automatic logic [FP_W-1:0] fp_sub(input logic [FP_W-1:0] a,
                                             input logic [FP_W-1:0] b);
    return fp_add(a, {~b[31], b[30:0]});
  endfunction

  function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a,
                                             input logic [FP_W-1:0] b);
    logic        s;
    logic [23:0] ma, mb;
    logic [47:0] p;
    logic [26:0] m, mask;
    int          ea, eb, ex, sh;
    s = a[31] ^ b[31];
    if ((a[30:23] == EXP_MAX && a[22:0] != 23'd0) ||
        (b[30:23] == EXP_MAX && b[22:0] != 23'd0)) return QNAN;
    if (a[30:23] == EXP_MAX) return (b[30:0] == 31'd0) ? QNAN : {s, EXP_MAX, 23'd0};
    if (b[30:23] == EXP_MAX) return (a[30:0] == 31'd0) ? QNAN : {s, EXP_MAX, 23'd0};
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    ea = (a[30:23] == EXP_ZERO) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == EXP_ZERO) ? 1 : int'(b[30:23]);
    ma = {a[30:23] != EXP_ZERO, a[22:0]};
    mb = {b[30:23] != EXP_ZERO, b[22:0]};
    for (int i = 0; i < 24; i++) begin
      if (!ma[23]) begin ma = ma << 1; ea = ea - 1; end
      if (!mb[23]) begin mb = mb << 1; eb = eb - 1; end
    end
    ex = ea + eb - 127;
    p  = {24'd0, ma} * {24'd0, mb};
    if (p[47]) ex = ex + 1;
    else       p  = p << 1;
    m = {p[47:22], |p[21:0]};
    // underflow: denormalise with sticky before rounding
    if (ex < 1) begin
      sh = 1 - ex;
      if (sh > 26) begin
        m = {26'd0, |m};
      end else begin
        mask = (27'd1 << sh) - 27'd1;
        m    = (m >> sh) | {26'd0, |(m & mask)};
      end
      ex = 1;
    end
    return fp_round_pack(s, ex, m);
  endfunction

endpackage

// File: rtl/fp_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH 0 is a plain wire.
module fp_delay_line #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ en;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/istage4.sv
// First inverse-DCT stage: undo the forward butterfly/scale, all lanes latency-aligned.
// ISTAGE4_HALF_SCALE_EN: when defined, O4/O7 are halved; otherwise they are the raw difference/sum.
module istage4
  import idct_pkg::*;
#(
  parameter int unsigned LAT_ADD = 11,
  parameter int unsigned LAT_MUL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [FP_W-1:0]  D0,
  input  logic [FP_W-1:0]  D1,
  input  logic [FP_W-1:0]  D2,
  input  logic [FP_W-1:0]  D3,
  input  logic [FP_W-1:0]  D4,
  input  logic [FP_W-1:0]  D5,
  input  logic [FP_W-1:0]  D6,
  input  logic [FP_W-1:0]  D7,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [FP_W-1:0]  O0,
  output logic [FP_W-1:0]  O1,
  output logic [FP_W-1:0]  O2,
  output logic [FP_W-1:0]  O3,
  output logic [FP_W-1:0]  O4,
  output logic [FP_W-1:0]  O5,
  output logic [FP_W-1:0]  O6,
  output logic [FP_W-1:0]  O7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [ROW_W-1:0] row_idx
);

  localparam int unsigned P = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;

  logic                  adv;
  logic [2*FP_W-1:0]     add_c, add_core, add_t;
  logic [2*FP_W-1:0]     mul_c, mul_core, mul_t;
  logic [4*FP_W-1:0]     pass_t;
  logic                  v_tail;
  logic [FP_W-1:0]       sum_t, dif_t, o7_c, o4_c;
  logic                  valid_next;
  logic [ROW_W-1:0]      row_next;

  // A single advance strobe freezes every stage when the output is blocked.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign add_c = {fp_add(D1, D7), fp_sub(D1, D7)};
  assign mul_c = {fp_mul(D3, INV_SQRT2), fp_mul(D5, INV_SQRT2)};

  fp_delay_line #(.WIDTH(2*FP_W), .DEPTH(LAT_ADD)) u_add_core (
    .clk(clk), .rst(reset), .en(adv), .d(add_c), .q(add_core));

  fp_delay_line #(.WIDTH(2*FP_W), .DEPTH(P - LAT_ADD)) u_add_pad (
    .clk(clk), .rst(reset), .en(adv), .d(add_core), .q(add_t));

  fp_delay_line #(.WIDTH(2*FP_W), .DEPTH(LAT_MUL)) u_mul_core (
    .clk(clk), .rst(reset), .en(adv), .d(mul_c), .q(mul_core));

  fp_delay_line #(.WIDTH(2*FP_W), .DEPTH(P - LAT_MUL)) u_mul_pad (
    .clk(clk), .rst(reset), .en(adv), .d(mul_core), .q(mul_t));

  fp_delay_line #(.WIDTH(4*FP_W), .DEPTH(P)) u_pass (
    .clk(clk), .rst(reset), .en(adv), .d({D0, D4, D2, D6}), .q(pass_t));

  fp_delay_line #(.WIDTH(1), .DEPTH(P)) u_valid (
    .clk(clk), .rst(reset), .en(adv), .d(in_valid && in_ready), .q(v_tail));

  assign {sum_t, dif_t} = add_t;

`ifdef ISTAGE4_HALF_SCALE_EN
  assign o7_c = fp_half(sum_t);
  assign o4_c = fp_half(dif_t);
`else
  assign o7_c = sum_t;
  assign o4_c = dif_t;
`endif

  // Next output-valid and row count; out_last is registered from these.
  always_comb begin
    valid_next = out_valid;
    row_next   = row_idx;
    if (adv) valid_next = v_tail;
    if (out_valid && out_ready) row_next = row_idx + ROW_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      row_idx   <= '0;
      O0 <= '0; O1 <= '0; O2 <= '0; O3 <= '0;
      O4 <= '0; O5 <= '0; O6 <= '0; O7 <= '0;
    end else begin
      out_valid <= valid_next;
      row_idx   <= row_next;
      out_last  <= valid_next && (row_next == {ROW_W{1'b1}});
      if (adv && v_tail) begin
        {O0, O1, O2, O3} <= pass_t;
        {O5, O6}         <= mul_t;
        O4               <= o4_c;
        O7               <= o7_c;
      end
    end
  end

endmodule

// File: doc/istage4.md
Name: istage4

Overview:
- First stage of the floating-point 8-point inverse DCT in the JPEG decode path.
- Exact inverse of the forward DCT's final butterfly/scaling stage.
- Takes one 8-element IEEE-754 single-precision coefficient vector per handshake and produces the un-butterflied vector for the next inverse stage.
- All eight lanes are latency-aligned. A row counter marks the end of each 8x8 block.

Parameters:
- LAT_ADD, 11, latency in cycles of the team's Adder/Subtracter FP cores.
- LAT_MUL, 8, latency in cycles of the team's Multiplier FP core.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- D0..D7  in  32 each  input coefficient vector, FP32
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector this cycle
- O0..O7  out  32 each  reconstructed vector, FP32
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts the output
- out_last  out  1  output is row 7 of the current 8x8 block
- row_idx  out  3  row number (0..7) of the current output

Behaviour:
- Lane mapping:
  - O0=D0, O1=D4, O2=D2, O3=D6
  - O5=D3*INV_SQRT2, O6=D5*INV_SQRT2
  - O7=half(D1+D7), O4=half(D1-D7)
  - INV_SQRT2 = 32'h3F3504F3.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - The whole pipeline, including FP core clock enables, delay lines and the valid shift register, moves only when adv=1.
  - When adv=0 every stage holds; no data is lost or duplicated.
- Latency:
  - P = max(LAT_ADD, LAT_MUL) advancing cycles through the datapath.
  - The half() stage is combinational and is folded into the output register.
  - Shorter paths (pass-through lanes, multiplier lanes if LAT_MUL<LAT_ADD) are padded with delay lines to P.
  - Total latency from an accepted input to out_valid is P+1 advancing cycles.
  - Throughput is 1 vector/cycle when out_ready is held high.
- Valid shift register:
  - Depth P, fed by in_valid&in_ready; its tail loads the output register.
  - out_valid stays high until out_valid&out_ready, or is reloaded in the same cycle by the next vector.
- half(x), by exponent field e:
  - e==0 (zero or denormal) → x unchanged.
  - e==255 (Inf/NaN) → x unchanged.
  - e==1 → signed zero (flush).
  - otherwise e-1 with sign and mantissa kept.
- Row counter:
  - Increments mod 8 on each output handshake (out_valid&out_ready).
  - row_idx shows the counter value; out_last = out_valid && row_idx==7.
  - Wraps 7→0 after the handshake.
- Reset, asynchronous, any cycle including mid-block or mid-pipeline:
  - out_valid=0, all valid bits=0, row_idx=0, out_last=0, O0..O7=0.
  - FP cores are held via aresetn = !reset.
  - In-flight vectors are discarded and the first output after reset is row 0.
  - in_ready=1 while out_valid=0.
- Simultaneous out handshake and new tail data: the output register reloads in the same cycle, with no bubble.
- Stall on the row-7 output: out_last stays high until its handshake completes.

Optional Feature:
- Macro ISTAGE4_HALF_SCALE_EN.
- Defined: O4/O7 pass through half() as above.
- Undefined:
  - O4 = D1-D7 and O7 = D1+D7, unscaled; the factor 2 is folded into the dequantisation table.
  - The half() logic is removed; latency is unchanged.

Decomposition:
- Package idct_pkg:
  - FP32 width constant, INV_SQRT2, FP exponent field bounds.
  - Function fp_half.
  - Row-counter width constant.
- Sub-module fp_delay_line: parameters WIDTH and DEPTH, with clock enable and async reset.
  - Used for the four pass-through lanes, the multiplier padding and the valid shift register.

Test Plan:
1. Butterfly lanes: D1=32'h40400000 (3.0), D7=32'h3F800000 (1.0), out_ready=1 → after P+1 cycles O7=32'h40000000 (2.0) and O4=32'h3F800000 (1.0). With the macro undefined → O7=32'h40800000 (4.0), O4=32'h40000000 (2.0).
2. Scale lanes and pass-through: D3=D5=32'h3FB504F3 (√2), D0=1.0, D4=2.0, D2=3.0, D6=4.0 → O5=O6=32'h3F800000 ±1 ulp; O0..O3 = 1.0, 2.0, 3.0, 4.0, all valid in the same output cycle.
3. Streaming with row counter: 16 back-to-back vectors with out_ready=1 → 16 consecutive out_valid cycles; out_last on outputs 8 and 16; row_idx sequence 0..7,0..7.
4. Backpressure: out_ready low for 5 cycles mid-stream → in_ready low during the stall; outputs are held stable; the sequence matches the no-stall reference exactly.
5. half() corners: D1=32'h00800000, D7=0 → O7=32'h00000000 (flush). D1=+Inf → O7=+Inf. D1=D7=0 → O7=O4=+0.
6. Reset mid-operation: assert reset while 4 vectors are in flight and row_idx=5 → out_valid=0 immediately; after release the first new vector emerges with row_idx=0 and none of the old vectors appear.
